// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the three-stage pipeline sequencing controller.
package pipe_ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Instruction the IF/E register loads when E is flushed.
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for debug event counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    // Count qualifying cycles, holding at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (inc && !(&q))
            q <= q + W'(1);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect, WB->E forwarding and data-memory handshake control
// for the Fetch / Execute / Writeback pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode_E,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic             br_taken_E,
    input  logic [4:0]       rd_W,
    input  logic             reg_wr_W,
    input  logic             mem_op_W,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stall,
    output logic             flush_E,
    output logic             pc_sel,
    output logic             fwd_A,
    output logic             fwd_B,
    output logic [1:0]       state,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WAIT_ONE  = WC_W'(1);

    ctrl_state_t     state_q, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            err_set;
    logic            mem_hold;
    logic            stall_c, req_c, live;
    logic            xfer;

    assign mem_hold = mem_op_W & ~dmem_ready;

    // Next-state and raw control; unused encoding 3 behaves as ERR.
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        stall_c   = 1'b0;
        req_c     = 1'b0;
        live      = 1'b0;
        case (state_q)
            RUN: begin
                req_c   = mem_op_W;
                stall_c = mem_hold;
                live    = 1'b1;
                if (mem_hold) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                req_c   = mem_op_W;
                stall_c = ~dmem_ready;
                live    = 1'b1;
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                    err_set   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                stall_c   = 1'b1;
                state_nxt = ERR;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                bus_err <= 1'b1;
        end
    end

    // Redirect only when E is free to advance; a stalled branch is
    // simply re-evaluated when the stall drops.
    always_comb begin
        xfer = (opcode_E == OP_JAL) | (opcode_E == OP_JALR) |
               ((opcode_E == OP_BRANCH) & br_taken_E);
    end

    assign stall    = reset & stall_c;
    assign dmem_req = reset & req_c;
    assign flush_E  = reset & live & ~stall_c & xfer;
    assign pc_sel   = flush_E;
    assign fwd_A    = reset & live & reg_wr_W & (rd_W != 5'd0) & (rd_W == rs1_E);
    assign fwd_B    = reset & live & reg_wr_W & (rd_W != 5'd0) & (rd_W == rs2_E);
    assign state    = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_E),
        .q     (flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// hand sequences for memory wait, held redirect, timeout and saturation.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode_E;
    logic [4:0]    rs1_E, rs2_E, rd_W;
    logic          br_taken_E, reg_wr_W, mem_op_W, dmem_ready;
    logic          dmem_req, stall, flush_E, pc_sel, fwd_A, fwd_B, bus_err;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode_E(opcode_E), .rs1_E(rs1_E),
        .rs2_E(rs2_E), .br_taken_E(br_taken_E), .rd_W(rd_W),
        .reg_wr_W(reg_wr_W), .mem_op_W(mem_op_W), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .stall(stall), .flush_E(flush_E),
        .pc_sel(pc_sel), .fwd_A(fwd_A), .fwd_B(fwd_B), .state(state),
        .bus_err(bus_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       br, wr, mop, rdy;
        logic       e_stall, e_flush, e_fa, e_fb, e_req;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic neutral();
        opcode_E = OP_R; rs1_E = 5'd1; rs2_E = 5'd2; rd_W = 5'd0;
        br_taken_E = 1'b0; reg_wr_W = 1'b0; mem_op_W = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        //            op        rs1 rs2 rd br wr mop rdy  st fl fa fb rq
        vecs[0]  = '{OP_R,      1,  2,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        vecs[1]  = '{OP_BRANCH, 1,  2,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        vecs[2]  = '{OP_BRANCH, 1,  2,  0, 1, 0, 0,  0,   0, 1, 0, 0, 0};
        vecs[3]  = '{OP_JAL,    1,  2,  0, 0, 0, 0,  0,   0, 1, 0, 0, 0};
        vecs[4]  = '{OP_JALR,   1,  2,  0, 0, 0, 0,  0,   0, 1, 0, 0, 0};
        vecs[5]  = '{7'h7f,     1,  2,  0, 1, 0, 0,  0,   0, 0, 0, 0, 0};
        vecs[6]  = '{OP_LOAD,   1,  2,  0, 1, 0, 0,  0,   0, 0, 0, 0, 0};
        vecs[7]  = '{OP_BRANCH, 1,  2,  0, 1, 0, 1,  0,   1, 0, 0, 0, 1};
        vecs[8]  = '{OP_BRANCH, 1,  2,  0, 1, 0, 1,  1,   0, 1, 0, 0, 1};
        vecs[9]  = '{OP_R,      5,  5,  5, 0, 1, 0,  0,   0, 0, 1, 1, 0};
        vecs[10] = '{OP_R,      0,  2,  0, 0, 1, 0,  0,   0, 0, 0, 0, 0};
        vecs[11] = '{OP_R,      5,  5,  5, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        vecs[12] = '{OP_R,      5,  6,  6, 0, 1, 0,  0,   0, 0, 0, 1, 0};
        vecs[13] = '{OP_R,      3,  2,  3, 0, 1, 1,  0,   1, 0, 1, 0, 1};

        // Reset asserted with hazardous inputs: everything forced low.
        reset = 1'b0;
        neutral();
        opcode_E = OP_JAL; mem_op_W = 1'b1; reg_wr_W = 1'b1; rd_W = 5'd1;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush_E, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_fwdA", fwd_A, 0);
        @(negedge clk);
        neutral();
        reset = 1'b1;
        step();
        chk("idle_stall", stall, 0);
        chk("idle_flush", flush_E, 0);
        chk("idle_pcsel", pc_sel, 0);
        chk("idle_state", state, 0);
        chk("idle_scnt", stall_cnt, 0);
        chk("idle_fcnt", flush_cnt, 0);

        // Combinational table in RUN; inputs return to neutral before each edge.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            opcode_E = vecs[i].op; rs1_E = vecs[i].rs1; rs2_E = vecs[i].rs2;
            rd_W = vecs[i].rd; br_taken_E = vecs[i].br; reg_wr_W = vecs[i].wr;
            mem_op_W = vecs[i].mop; dmem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("v%0d_flush", i), flush_E, vecs[i].e_flush);
            chk($sformatf("v%0d_pcsel", i), pc_sel, vecs[i].e_flush);
            chk($sformatf("v%0d_fwdA", i), fwd_A, vecs[i].e_fa);
            chk($sformatf("v%0d_fwdB", i), fwd_B, vecs[i].e_fb);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            #2;
            neutral();
        end
        step();
        chk("tbl_state", state, 0);
        chk("tbl_scnt", stall_cnt, 0);
        chk("tbl_fcnt", flush_cnt, 0);

        // Three-cycle memory wait.
        mem_op_W = 1'b1; #1;
        chk("mw1_state", state, 0); chk("mw1_stall", stall, 1); chk("mw1_req", dmem_req, 1);
        step(); chk("mw2_state", state, 1); chk("mw2_stall", stall, 1);
        step(); chk("mw3_state", state, 1); chk("mw3_stall", stall, 1);
        step(); dmem_ready = 1'b1; #1;
        chk("mw4_state", state, 1); chk("mw4_stall", stall, 0);
        step(); neutral(); #1;
        chk("mw5_state", state, 0); chk("mw5_stall", stall, 0);
        chk("mw_scnt", stall_cnt, 3);

        // Taken branch then not-taken branch.
        opcode_E = OP_BRANCH; br_taken_E = 1'b1; #1;
        chk("br_flush", flush_E, 1); chk("br_pcsel", pc_sel, 1);
        step(); neutral(); #1;
        chk("br_fcnt", flush_cnt, 1); chk("br_flush_after", flush_E, 0);
        opcode_E = OP_BRANCH; br_taken_E = 1'b0; #1;
        chk("bnt_flush", flush_E, 0);
        step(); neutral(); #1;
        chk("bnt_fcnt", flush_cnt, 1);

        // JAL held behind a two-cycle memory hold.
        opcode_E = OP_JAL; mem_op_W = 1'b1; #1;
        chk("jh1_flush", flush_E, 0); chk("jh1_stall", stall, 1);
        step(); chk("jh2_flush", flush_E, 0); chk("jh2_state", state, 1);
        step(); dmem_ready = 1'b1; #1;
        chk("jh3_flush", flush_E, 1); chk("jh3_pcsel", pc_sel, 1); chk("jh3_stall", stall, 0);
        step(); neutral(); #1;
        chk("jh_state", state, 0); chk("jh_fcnt", flush_cnt, 2); chk("jh_scnt", stall_cnt, 5);

        // Timeout into ERR (MEM_TIMEOUT=4), with a redirect and a forward pending.
        opcode_E = OP_JAL; reg_wr_W = 1'b1; rd_W = 5'd1; rs1_E = 5'd1; mem_op_W = 1'b1; #1;
        chk("to1_state", state, 0); chk("to1_stall", stall, 1);
        step(); chk("to2_state", state, 1);
        step(); chk("to3_state", state, 1);
        step(); chk("to4_state", state, 1); chk("to4_err", bus_err, 0);
        step();
        chk("to_state", state, 2); chk("to_err", bus_err, 1);
        chk("to_req", dmem_req, 0); chk("to_stall", stall, 1);
        chk("to_flush", flush_E, 0); chk("to_pcsel", pc_sel, 0); chk("to_fwdA", fwd_A, 0);
        dmem_ready = 1'b1; #1;
        chk("err_ready_stall", stall, 1);
        for (int i = 0; i < 8; i++) step();
        chk("err_hold_state", state, 2);
        chk("scnt_sat", stall_cnt, 15);

        // Asynchronous reset mid-cycle in ERR.
        #2; reset = 1'b0; #1;
        chk("rerr_state", state, 0); chk("rerr_err", bus_err, 0);
        chk("rerr_stall", stall, 0); chk("rerr_scnt", stall_cnt, 0);
        neutral();
        @(negedge clk); reset = 1'b1;
        step();
        chk("post_state", state, 0); chk("post_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
